// File: rtl/clk_buf_multi.sv
// Multi-channel glitch-free clock divider. Each channel owns a shadow config,
// and runs an IDLE/PHASE/HIGH/LOW counter FSM that applies shadow updates only at safe points.

module clk_buf_multi_ch #(
    parameter int DIVW = 8
) (
    input  logic            mclk,
    input  logic            rst_n,
    input  logic            wr_i,
    input  logic [DIVW-1:0] half_i,
    input  logic [DIVW-1:0] phase_i,
    input  logic            en_i,
    output logic            bclk_o,
    output logic            locked_o
);
    typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} st_e;

    st_e             state_q, state_d;
    logic [DIVW-1:0] cnt_q, cnt_d;
    logic [DIVW-1:0] act_h_q, act_h_d;
    logic [DIVW-1:0] sh_h_q, sh_p_q;
    logic            sh_en_q;
    logic            locked_q, locked_d;
    logic            bclk_q;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            act_h_q  <= '0;
            sh_h_q   <= '0;
            sh_p_q   <= '0;
            sh_en_q  <= 1'b0;
            locked_q <= 1'b0;
            bclk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            act_h_q  <= act_h_d;
            locked_q <= locked_d;
            bclk_q   <= (state_d == HIGH);
            if (wr_i) begin
                sh_h_q  <= half_i;
                sh_p_q  <= phase_i;
                sh_en_q <= en_i;
            end
        end
    end

    // The FSM reads the shadow as it stood before this edge, so a write that
    // lands on a boundary is picked up at the next boundary.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        act_h_d  = act_h_q;
        locked_d = locked_q;
        case (state_q)
            IDLE: begin
                locked_d = 1'b0;
                if (sh_en_q) begin
                    act_h_d = sh_h_q;
                    if (sh_p_q == '0) begin
                        state_d = HIGH;
                        cnt_d   = sh_h_q;
                    end else begin
                        state_d = PHASE;
                        cnt_d   = sh_p_q - DIVW'(1);
                    end
                end
            end
            PHASE: begin
                if (!sh_en_q) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = act_h_q;
                end else begin
                    cnt_d = cnt_q - DIVW'(1);
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = LOW;
                    cnt_d   = act_h_q;
                end else begin
                    cnt_d = cnt_q - DIVW'(1);
                end
            end
            LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIVW'(1);
                end else if (!sh_en_q) begin
                    state_d  = IDLE;
                    locked_d = 1'b0;
                end else if (sh_h_q != act_h_q) begin
                    state_d  = HIGH;
                    act_h_d  = sh_h_q;
                    cnt_d    = sh_h_q;
                    locked_d = 1'b0;
                end else begin
                    state_d  = HIGH;
                    cnt_d    = act_h_q;
                    locked_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bclk_o   = bclk_q;
    assign locked_o = locked_q;
endmodule

module clk_buf_multi #(
    parameter int NCH  = 4,
    parameter int DIVW = 8
) (
    input  logic            mclk,
    input  logic            rst_n,
    input  logic            cfg_wr,
    input  logic [3:0]      cfg_ch,
    input  logic [DIVW-1:0] cfg_half,
    input  logic [DIVW-1:0] cfg_phase,
    input  logic            cfg_en,
    output logic            cfg_ack,
    output logic            cfg_err,
    output logic [NCH-1:0]  bclk,
    output logic [NCH-1:0]  locked
);
    logic ch_ok;
    logic ack_q, err_q;

    assign ch_ok = {1'b0, cfg_ch} < 5'(NCH);

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= cfg_wr & ch_ok;
            err_q <= cfg_wr & ~ch_ok;
        end
    end

    assign cfg_ack = ack_q;
    assign cfg_err = err_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_buf_multi_ch #(.DIVW(DIVW)) u_ch (
            .mclk    (mclk),
            .rst_n   (rst_n),
            .wr_i    (cfg_wr && ch_ok && (cfg_ch == 4'(g))),
            .half_i  (cfg_half),
            .phase_i (cfg_phase),
            .en_i    (cfg_en),
            .bclk_o  (bclk[g]),
            .locked_o(locked[g])
        );
    end
endmodule

// File: tb/tb_clk_buf_multi.sv
// Scoreboard bench for clk_buf_multi: stimulus queues expected config responses
// and bclk edge cycles; a negedge monitor pops and compares as the DUT produces them.
`timescale 1us/1ns
module tb_clk_buf_multi;
    logic       mclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [3:0] cfg_ch = '0;
    logic [7:0] cfg_half = '0;
    logic [7:0] cfg_phase = '0;
    logic       cfg_en = 1'b0;
    logic       cfg_ack, cfg_err;
    logic [3:0] bclk, locked;

    clk_buf_multi #(.NCH(4), .DIVW(8)) dut (
        .mclk(mclk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_half(cfg_half), .cfg_phase(cfg_phase), .cfg_en(cfg_en),
        .cfg_ack(cfg_ack), .cfg_err(cfg_err), .bclk(bclk), .locked(locked)
    );

    always #1953.125 mclk = ~mclk;

    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    bit   mon_on = 1'b0;
    int   cfg_q[$];
    int   exp_q[4][$];
    logic [3:0] prev = '0;

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // cfg entries: cycle*4 + {ack,err}; edge entries: cycle*2 + new level
    always @(negedge mclk) begin
        if (cfg_ack || cfg_err) begin
            if (cfg_q.size() == 0) chk("cfg_unexpected", cyc * 4 + {cfg_ack, cfg_err}, -1);
            else chk("cfg_resp", cyc * 4 + {cfg_ack, cfg_err}, cfg_q.pop_front());
        end
        for (int ch = 0; ch < 4; ch++) begin
            if (mon_on && bclk[ch] !== prev[ch]) begin
                if (exp_q[ch].size() == 0)
                    chk($sformatf("bclk%0d_unexpected_edge", ch), cyc * 2 + int'(bclk[ch]), -1);
                else
                    chk($sformatf("bclk%0d_edge", ch), cyc * 2 + int'(bclk[ch]), exp_q[ch].pop_front());
            end
        end
        prev = bclk;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic write(input int ch, input int h, input int p, input bit en, output int k);
        cfg_ch = 4'(ch); cfg_half = 8'(h); cfg_phase = 8'(p); cfg_en = en;
        cfg_wr = 1'b1;
        k = cyc + 1;
        cfg_q.push_back(k * 4 + ((ch < 4) ? 2 : 1));
        tick(1);
        cfg_wr = 1'b0;
    endtask

    task automatic exp_run(input int ch, input int r, input int h, input int stop);
        for (int t = r; t < stop; t += 2 * (h + 1)) begin
            exp_q[ch].push_back(t * 2 + 1);
            if (t + h + 1 < stop) exp_q[ch].push_back((t + h + 1) * 2);
        end
    endtask

    // Asynchronous reset mid-run, then verify everything queued was seen.
    task automatic scen_end(input string nm);
        mon_on = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({nm, "_rst_bclk"}, int'(bclk), 0);
        chk({nm, "_rst_locked"}, int'(locked), 0);
        chk({nm, "_rst_ack"}, int'(cfg_ack), 0);
        chk({nm, "_cfg_left"}, cfg_q.size(), 0);
        for (int ch = 0; ch < 4; ch++) begin
            chk($sformatf("%s_edges_left%0d", nm, ch), exp_q[ch].size(), 0);
            exp_q[ch].delete();
        end
        cfg_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(1);
        mon_on = 1'b1;
    endtask

    initial begin
        int k, k2;
        tick(2);
        chk("reset_bclk", int'(bclk), 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_ack_err", int'({cfg_ack, cfg_err}), 0);
        rst_n = 1'b1;
        tick(1);
        mon_on = 1'b1;

        // ch0 H=0 P=0: mclk/2, locked after first period
        write(0, 0, 0, 1'b1, k);
        exp_run(0, k + 1, 0, k + 20);
        tick(2); chk("s2_locked0_early", int'(locked[0]), 0);
        tick(1); chk("s2_locked0", int'(locked[0]), 1);
        tick(17);
        scen_end("s2");

        // ch2 H=3 P=0, then ch1 H=3 P=5 one cycle later
        write(2, 3, 0, 1'b1, k);
        write(1, 3, 5, 1'b1, k2);
        exp_run(2, k + 1, 3, k + 40);
        exp_run(1, k + 7, 3, k + 40);
        tick(7); chk("s3_locked2_early", int'(locked[2]), 0);
        tick(1); chk("s3_locked2", int'(locked[2]), 1);
        tick(5); chk("s3_locked1_early", int'(locked[1]), 0);
        tick(1); chk("s3_locked1", int'(locked[1]), 1);
        tick(25);
        scen_end("s3");

        // ch0 H=1 running, H=4 written during HIGH
        write(0, 1, 0, 1'b1, k);
        exp_run(0, k + 1, 1, k + 13);
        tick(9);
        write(0, 4, 0, 1'b1, k2);
        exp_run(0, k + 13, 4, k + 40);
        tick(2); chk("s4_locked_old", int'(locked[0]), 1);
        tick(1); chk("s4_locked_drop", int'(locked[0]), 0);
        tick(9); chk("s4_locked_still0", int'(locked[0]), 0);
        tick(1); chk("s4_locked_back", int'(locked[0]), 1);
        tick(17);
        scen_end("s4");

        // ch3 H=2 disabled at first HIGH cycle: one full pulse, then quiet
        write(3, 2, 0, 1'b1, k);
        exp_run(3, k + 1, 2, k + 7);
        write(3, 2, 0, 1'b0, k2);
        tick(13);
        chk("s5_bclk3_off", int'(bclk[3]), 0);
        chk("s5_locked3", int'(locked[3]), 0);
        tick(10);
        scen_end("s5");

        // Out-of-range channel write while ch0 runs
        write(0, 0, 0, 1'b1, k);
        exp_run(0, k + 1, 0, k + 20);
        tick(3);
        write(4, 5, 0, 1'b1, k2);
        tick(1);
        chk("s6_bclk_hi", int'(bclk[3:1]), 0);
        tick(15);
        scen_end("s6");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
